// File: rtl/bridge_req_arbiter.sv
// bridge_req_arbiter: round-robin sharing of one DRAM<->SD bridge between two queued requesters.
// Define BRIDGE_ARB_TIMEOUT_EN to add the WAIT watchdog and the err_timeout output.
module bridge_req_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYC    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_dir,
    input  logic [12:0] req0_addr_dram,
    input  logic [15:0] req0_addr_sd,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_dir,
    input  logic [12:0] req1_addr_dram,
    input  logic [15:0] req1_addr_sd,
    output logic        br_in_valid,
    output logic        br_direction,
    output logic [12:0] br_addr_dram,
    output logic [15:0] br_addr_sd,
    input  logic        br_out_valid,
    input  logic [7:0]  br_out_data,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [7:0]  rsp_data,
    output logic        rsp_last,
    output logic        busy
`ifdef BRIDGE_ARB_TIMEOUT_EN
    ,
    output logic        err_timeout
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t           state, state_n;
    logic             grant_id, grant_n, rr, rr_n;
    logic [2:0]       byte_cnt, byte_n;
    logic [GW-1:0]    gap_cnt, gap_n;
    logic             rsp_valid_n, rsp_id_n, rsp_last_n;
    logic [7:0]       rsp_data_n;
    logic [1:0]       valid, ready, push, pop, nonempty;
    logic [1:0][29:0] din, head;
`ifdef BRIDGE_ARB_TIMEOUT_EN
    logic [15:0]      wd, wd_n;
    logic             err_n;
`endif

    assign valid      = {req1_valid, req0_valid};
    assign din        = {{req1_dir, req1_addr_dram, req1_addr_sd}, {req0_dir, req0_addr_dram, req0_addr_sd}};
    assign push       = valid & ready;
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [29:0]   mem [FIFO_DEPTH];
        logic [AW-1:0] wr_ptr, rd_ptr;
        logic [AW:0]   cnt;
        assign ready[g]    = cnt != (AW+1)'(FIFO_DEPTH);
        assign nonempty[g] = cnt != '0;
        assign head[g]     = mem[rd_ptr];
        assign pop[g]      = state == ISSUE && grant_id == 1'(g);
        always_ff @(posedge clk) begin
            if (push[g]) mem[wr_ptr] <= din[g];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[g]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[g]) rd_ptr <= rd_ptr + 1'b1;
                cnt <= cnt + (AW+1)'(push[g]) - (AW+1)'(pop[g]);
            end
        end
    end

    assign br_in_valid = state == ISSUE;
    assign {br_direction, br_addr_dram, br_addr_sd} = br_in_valid ? head[grant_id] : '0;
    assign busy = state != IDLE;

    always_comb begin
        state_n     = state;
        grant_n     = grant_id;
        rr_n        = rr;
        byte_n      = byte_cnt;
        gap_n       = gap_cnt;
        rsp_valid_n = 1'b0;
        rsp_id_n    = 1'b0;
        rsp_data_n  = '0;
        rsp_last_n  = 1'b0;
`ifdef BRIDGE_ARB_TIMEOUT_EN
        wd_n        = wd;
        err_n       = 1'b0;
`endif
        case (state)
            IDLE: if (|nonempty) begin
                // rr only matters when both queues hold work
                grant_n = nonempty[1] & (~nonempty[0] | rr);
                rr_n    = ~grant_n;
                state_n = ISSUE;
            end
            ISSUE: begin
                state_n = WAIT;
                byte_n  = '0;
`ifdef BRIDGE_ARB_TIMEOUT_EN
                wd_n    = '0;
`endif
            end
            WAIT: begin
                if (br_out_valid) begin
                    rsp_valid_n = 1'b1;
                    rsp_id_n    = grant_id;
                    rsp_data_n  = br_out_data;
                    byte_n      = byte_cnt + 3'd1;
`ifdef BRIDGE_ARB_TIMEOUT_EN
                    wd_n        = '0;
`endif
                    if (byte_cnt == 3'd7) begin
                        rsp_last_n = 1'b1;
                        state_n    = GAP;
                        gap_n      = GW'(GAP_CYC - 1);
                    end
                end
`ifdef BRIDGE_ARB_TIMEOUT_EN
                else if (wd == 16'hFFFF) begin
                    rsp_valid_n = 1'b1;
                    rsp_id_n    = grant_id;
                    rsp_data_n  = 8'hEE;
                    rsp_last_n  = 1'b1;
                    err_n       = 1'b1;
                    state_n     = GAP;
                    gap_n       = GW'(GAP_CYC - 1);
                end else begin
                    wd_n = wd + 16'd1;
                end
`endif
            end
            // leaving at count 1 lets the IDLE cycle serve as the final gap cycle
            GAP: if (gap_cnt <= GW'(1)) state_n = IDLE; else gap_n = gap_cnt - 1'b1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_id  <= 1'b0;
            rr        <= 1'b0;
            byte_cnt  <= '0;
            gap_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
`ifdef BRIDGE_ARB_TIMEOUT_EN
            wd          <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            grant_id  <= grant_n;
            rr        <= rr_n;
            byte_cnt  <= byte_n;
            gap_cnt   <= gap_n;
            rsp_valid <= rsp_valid_n;
            rsp_id    <= rsp_id_n;
            rsp_data  <= rsp_data_n;
            rsp_last  <= rsp_last_n;
`ifdef BRIDGE_ARB_TIMEOUT_EN
            wd          <= wd_n;
            err_timeout <= err_n;
`endif
        end
    end

endmodule

// File: doc/bridge_req_arbiter.md
Name: bridge_req_arbiter

Overview:
- Front-end scheduler that shares one DRAM<->SD BRIDGE instance between two requesters (port 0, port 1).
- Each port queues transfer commands (direction, DRAM address, SD address) in a private FIFO.
- A round-robin arbiter issues one command at a time to the bridge, waits for its 8-byte out_valid burst, and routes each returned byte to the owning requester, tagged with the requester ID.

Parameters:
- FIFO_DEPTH, 4, entries per requester queue; power of two, at least 2.
- GAP_CYC, 2, idle cycles between the last bridge output byte and the next br_in_valid.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  port 0 command valid
- req0_ready  out  1  port 0 queue not full
- req0_dir  in  1  port 0 direction: 0 = DRAM->SD, 1 = SD->DRAM
- req0_addr_dram  in  13  port 0 DRAM address
- req0_addr_sd  in  16  port 0 SD address
- req1_valid, req1_ready, req1_dir, req1_addr_dram[12:0], req1_addr_sd[15:0]  as port 0, for port 1
- br_in_valid  out  1  one-cycle command strobe to the bridge
- br_direction  out  1  command direction to the bridge
- br_addr_dram  out  13  DRAM address to the bridge
- br_addr_sd  out  16  SD address to the bridge
- br_out_valid  in  1  bridge data byte valid
- br_out_data  in  8  bridge data byte
- rsp_valid  out  1  response byte valid
- rsp_id  out  1  owner of the response byte
- rsp_data  out  8  response byte
- rsp_last  out  1  marks the 8th byte of a transfer
- busy  out  1  asserted in any state other than IDLE

Behaviour:
- Reset: clk and rst_n as above; reset is asynchronous, active-low.
  - All outputs go to 0, except req0_ready = req1_ready = 1.
  - Both FIFOs are emptied, the state is IDLE, and the rr pointer is 0 (port 0 has first priority).
- FIFOs:
  - Push on reqN_valid && reqN_ready. reqN_ready = !fullN, a combinational function of the count only.
  - Entry is 30 bits: {dir, addr_dram, addr_sd}. Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
  - A pop happens only in ISSUE. A push and a pop on the same FIFO in the same cycle leave the count unchanged.
  - A valid request while the FIFO is full is ignored, and ready stays 0.
- IDLE:
  - If exactly one FIFO is non-empty, grant that port.
  - If both are non-empty, grant the port not served last (rr), then set rr = the other port.
  - Latch grant_id and go to ISSUE.
- ISSUE (1 cycle):
  - br_in_valid = 1; br_direction/br_addr_* come from the head of the granted FIFO.
  - Pop that FIFO, then go to WAIT. br_in_valid is 0 in every other state.
- WAIT:
  - Each cycle with br_out_valid = 1, the registered response is set next cycle: rsp_valid = 1, rsp_id = grant_id, rsp_data = br_out_data.
  - A 3-bit byte counter increments on each such cycle.
  - On the 8th byte, rsp_last = 1 with that byte; go to GAP and load the gap counter with GAP_CYC-1.
  - Response latency is exactly 1 cycle. rsp_valid is 0 whenever the matching br_out_valid was 0.
- GAP: count down to 0, then go to IDLE. The next br_in_valid is no earlier than GAP_CYC+1 cycles after the last br_out_valid.
- br_out_valid outside WAIT is ignored: no rsp_valid, no state change.
- The bridge is assumed to need an unbounded time per transfer. No timeout unless the optional feature below is compiled in.
- Reset mid-transfer clears all state and queued commands. The bridge is reset by the same rst_n.

Optional Feature:
- Macro BRIDGE_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles in WAIT without br_out_valid and clears on each byte.
  - At 16'hFFFF, the block emits one response with rsp_valid = 1, rsp_last = 1, rsp_data = 8'hEE and rsp_id = grant_id, then goes to GAP.
  - Output err_timeout (1 bit) pulses for 1 cycle at the same time.
- Not defined: no watchdog, no err_timeout port; WAIT waits indefinitely.

Test Plan:
- Single request: port 0 dir=1, addr_dram=0x0A5, addr_sd=0x1234.
  - Required: br_in_valid pulses once with those values.
  - Bridge model returns 0x01..0x08, giving rsp_valid for 8 cycles with rsp_id=0 and data 0x01..0x08 at 1-cycle latency; rsp_last only on 0x08.
- Simultaneous requests on both ports in the same cycle from reset: required issue order is port 0 then port 1, with the port 1 br_in_valid exactly GAP_CYC+1 cycles after the last port 0 byte.
- Fill port 1 with 4 requests while the bridge is busy: req1_ready = 0 after the 4th push, and a 5th request is dropped. Port 0 then submits 2: issue order 1,0,1,0,1,1.
- Push and pop in the same cycle on a full FIFO: req1_ready is still 0 the cycle before, so no push occurs, and the count goes 4->3.
- Assert rst_n low during WAIT after 3 bytes: all outputs return to reset values, and no further rsp_valid appears, even though the bridge model keeps driving out_valid before its own reset.
- With BRIDGE_ARB_TIMEOUT_EN, issue a request and have the bridge model never respond: after 65535 WAIT cycles, one rsp with data 0xEE, rsp_last = 1 and err_timeout = 1, then the FSM returns to IDLE.
